// File: rtl/sprite_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pixel_fetch
// Brief    : Turns arbiter sprite hits into registered VGA colour through a
//            sprite ROM, with transparency, blanking and sync alignment.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_pixel_fetch #(
    parameter int          ELEMENT      = 5,
    parameter int          SPRITE_WORDS = 400,
    parameter int          NUM_SPRITES  = 31,
    parameter int          MEM_AW       = 14,
    parameter logic [8:0]  TRANSPARENT  = 9'h1FF,
    parameter logic [8:0]  BACKGROUND   = 9'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                active,
    input  logic                h_sync_in,
    input  logic                v_sync_in,
    input  logic                ready,
    input  logic [ELEMENT-1:0]  element,
    input  logic [9:0]          address,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [8:0]          mem_data,
    output logic [8:0]          rgb,
    output logic                h_sync,
    output logic                v_sync,
    output logic                bad_sprite,
    output logic [7:0]          err_count
);

    localparam logic [31:0] c_MAX_ELEMENT = NUM_SPRITES;
    localparam logic [31:0] c_WORDS       = SPRITE_WORDS;

    logic              w_hit;
    logic              w_bad_element;
    logic              w_bad_address;
    logic              w_illegal;
    logic [MEM_AW-1:0] w_sum;

    logic r_act1, r_hit1, r_ill1, r_hs1, r_vs1;
    logic r_act2, r_hit2, r_ill2, r_hs2, r_vs2;

    assign w_hit         = ready & active;
    assign w_bad_element = (32'(element) == 32'd0) || (32'(element) > c_MAX_ELEMENT);
    assign w_bad_address = (32'(address) >= c_WORDS);
    assign w_illegal     = w_hit & (w_bad_element | w_bad_address);
    // Product kept at ROM address width; the sum wraps at MEM_AW bits.
    assign w_sum = (MEM_AW'(element) * MEM_AW'(SPRITE_WORDS)) + MEM_AW'(address);

    // Stage 1: qualify the hit and form the ROM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act1   <= 1'b0;
            r_hit1   <= 1'b0;
            r_ill1   <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            mem_addr <= '0;
        end else begin
            r_act1   <= active;
            r_hit1   <= w_hit & ~w_illegal;
            r_ill1   <= w_illegal;
            r_hs1    <= h_sync_in;
            r_vs1    <= v_sync_in;
            mem_addr <= w_illegal ? '0 : w_sum;
        end
    end

    // Stage 2: flags ride alongside the ROM's internal read register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act2 <= 1'b0;
            r_hit2 <= 1'b0;
            r_ill2 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
        end else begin
            r_act2 <= r_act1;
            r_hit2 <= r_hit1;
            r_ill2 <= r_ill1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    // Stage 3: blanking beats everything, then miss/transparent to background.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb        <= 9'h000;
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            bad_sprite <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (!r_act2)
                rgb <= 9'h000;
            else if (!r_hit2 || (mem_data == TRANSPARENT))
                rgb <= BACKGROUND;
            else
                rgb <= mem_data;
            h_sync     <= r_hs2;
            v_sync     <= r_vs2;
            bad_sprite <= r_ill2;
            if (r_ill2 && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_pixel_fetch
// Brief    : Scoreboard bench for sprite_pixel_fetch with a behavioural ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_pixel_fetch;

    localparam logic [8:0] BG = 9'h0A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        ready = 1'b0;
    logic [4:0]  element = '0;
    logic [9:0]  address = '0;
    logic [13:0] mem_addr;
    logic [8:0]  mem_data = '0;
    logic [8:0]  rgb;
    logic        h_sync, v_sync, bad_sprite;
    logic [7:0]  err_count;

    sprite_pixel_fetch #(
        .ELEMENT(5), .SPRITE_WORDS(400), .NUM_SPRITES(31), .MEM_AW(14),
        .TRANSPARENT(9'h1FF), .BACKGROUND(BG)
    ) dut (
        .clk(clk), .reset(reset), .active(active), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .ready(ready), .element(element),
        .address(address), .mem_addr(mem_addr), .mem_data(mem_data),
        .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync),
        .bad_sprite(bad_sprite), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [0:16383];
    always @(posedge clk) mem_data <= rom[mem_addr];

    typedef struct packed {
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
        logic       bad;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   model_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the colour a pixel must show, from the rules directly.
    task automatic push_current();
        exp_t e;
        logic hit, ill;
        int   idx;
        hit = ready & active;
        ill = hit && (element == 0 || element > 31 || address >= 400);
        if (ill && model_err < 255) model_err++;
        idx = int'(element) * 400 + int'(address);
        if (!active)             e.rgb = 9'h000;
        else if (!hit || ill)    e.rgb = BG;
        else if (rom[idx] == 9'h1FF) e.rgb = BG;
        else                     e.rgb = rom[idx];
        e.hs  = h_sync_in;
        e.vs  = v_sync_in;
        e.bad = ill;
        e.err = 8'(model_err);
        q.push_back(e);
    endtask

    task automatic drive(input logic a, input logic r, input logic [4:0] el,
                         input logic [9:0] ad, input logic hs, input logic vs);
        @(negedge clk);
        active = a; ready = r; element = el; address = ad;
        h_sync_in = hs; v_sync_in = vs;
        push_current();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 10'd0, 1'b1, 1'b1);
    endtask

    task automatic release_reset();
        exp_t blank;
        blank = '{rgb: 9'h000, hs: 1'b1, vs: 1'b1, bad: 1'b0, err: 8'd0};
        @(negedge clk);
        reset = 1'b1;
        q.push_back(blank);
        q.push_back(blank);
        active = 1'b0; ready = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        push_current();
    endtask

    // Monitor: every edge out of reset presents one pixel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                chk("reset_rgb", int'(rgb), 0);
                chk("reset_hs", int'(h_sync), 1);
                chk("reset_vs", int'(v_sync), 1);
                chk("reset_err", int'(err_count), 0);
                chk("reset_memaddr", int'(mem_addr), 0);
            end else if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("rgb", int'(rgb), int'(e.rgb));
                chk("h_sync", int'(h_sync), int'(e.hs));
                chk("v_sync", int'(v_sync), int'(e.vs));
                chk("bad_sprite", int'(bad_sprite), int'(e.bad));
                chk("err_count", int'(err_count), int'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            active = 1'($urandom); ready = 1'($urandom);
            element = 5'($urandom); address = 10'($urandom);
            h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
        end
        model_err = 0;
        release_reset();
        for (int i = 0; i < 3; i++) idle();

        // Basic fetch
        rom[2037] = 9'h1C0;
        drive(1'b1, 1'b1, 5'd5, 10'd37, 1'b1, 1'b1);
        @(posedge clk); #2;
        chk("basic_memaddr", int'(mem_addr), 2037);
        // Transparency and no-hit background
        rom[400] = 9'h1FF;
        drive(1'b1, 1'b1, 5'd1, 10'd0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 5'd9, 10'd9, 1'b1, 1'b1);
        // Blanking priority with sync patterns
        rom[1210] = 9'h0FF;
        drive(1'b0, 1'b1, 5'd3, 10'd10, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 5'd3, 10'd10, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 5'd3, 10'd10, 1'b0, 1'b0);
        // Illegal hits, plus illegal with active low (ignored)
        drive(1'b1, 1'b1, 5'd0, 10'd5, 1'b1, 1'b1);
        @(posedge clk); #2;
        chk("illegal_memaddr", int'(mem_addr), 0);
        drive(1'b1, 1'b1, 5'd31, 10'd400, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 5'd0, 10'd0, 1'b1, 1'b1);
        idle();
        @(posedge clk); #2;
        chk("err_after_two", int'(err_count), 2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)),
                  ($urandom_range(0, 9) == 0) ? 10'($urandom_range(400, 1023))
                                              : 10'($urandom_range(0, 399)),
                  1'($urandom), 1'($urandom));
        end

        // Streaming with a mid-line reset at pixel 10
        for (int a = 0; a < 20; a++) rom[2800 + a] = 9'(a);
        for (int a = 0; a < 10; a++)
            drive(1'b1, 1'b1, 5'd7, 10'(a), 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_rgb", int'(rgb), 0);
        chk("midreset_hs", int'(h_sync), 1);
        chk("midreset_bad", int'(bad_sprite), 0);
        chk("midreset_err", int'(err_count), 0);
        q.delete();
        model_err = 0;
        @(negedge clk);
        @(negedge clk);
        release_reset();
        for (int a = 10; a < 20; a++)
            drive(1'b1, 1'b1, 5'd7, 10'(a), 1'b1, 1'b1);

        // Saturation
        for (int i = 0; i < 300; i++)
            drive(1'b1, 1'b1, 5'd0, 10'($urandom_range(0, 399)), 1'b1, 1'b1);
        idle();
        idle();
        @(posedge clk); #2;
        chk("err_saturated", int'(err_count), 255);
        idle();
        idle();
        @(posedge clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
